pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 25 ++
 rtl/pipe_stage_reg_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 89 ++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: slot record, bubble
// constant, default reset PC and the saturating counter helper.
package pipe_stage_reg_pkg;

   // Widest result data a slot can carry; DW of the stage must not exceed it.
   localparam int MAX_DW = 64;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef struct packed {
      logic              valid;
      logic [4:0]        a3;
      logic [31:0]       pc;
      logic [MAX_DW-1:0] data;
      logic              reg_write;
   } slot_t;

   localparam slot_t BUBBLE = '{valid: 1'b0, a3: 5'd0, pc: 32'd0, data: '0, reg_write: 1'b0};

   // Counters up to 32 bits wide are widened to 32 bits for this helper.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One slot of the stage register: reset to a bubble at the reset PC, insert a
// bubble at a given PC, hold, or load the incoming record.
module pipe_slot
   import pipe_stage_reg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] reset_pc,
   input  logic [31:0] bubble_pc,
   input  slot_t       d,
   output slot_t       q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= BUBBLE;
         q.pc <= reset_pc;
      end else if (bubble) begin
         q    <= BUBBLE;
         q.pc <= bubble_pc;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Chain of DEPTH stage-register slots with stall/flush control and saturating
// bubble and stall performance counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int          DW       = 32,
   parameter int          DEPTH    = 1,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [4:0]    in_a3,
   input  logic [31:0]   in_pc,
   input  logic [DW-1:0] in_data,
   input  logic          in_reg_write,
   output logic          out_valid,
   output logic [4:0]    out_a3,
   output logic [31:0]   out_pc,
   output logic [DW-1:0] out_data,
   output logic          out_reg_write,
   output logic [CW-1:0] bubble_cnt,
   output logic [CW-1:0] stall_cnt
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   slot_t in_slot;
   slot_t slot_q [DEPTH];

   // An invalid entry never names a destination, and register 0 is never written.
   always_comb begin
      in_slot           = BUBBLE;
      in_slot.valid     = in_valid;
      in_slot.a3        = in_valid ? in_a3 : 5'd0;
      in_slot.pc        = in_pc;
      in_slot.data      = MAX_DW'(in_data);
      in_slot.reg_write = in_valid & in_reg_write & (in_a3 != 5'd0);
   end

   // A flush overrides stall: slot 0 takes the bubble while later slots advance.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      if (k == 0) begin : g_first
         pipe_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall),
            .bubble    (flush),
            .reset_pc  (RESET_PC),
            .bubble_pc (in_pc),
            .d         (in_slot),
            .q         (slot_q[k])
         );
      end else begin : g_rest
         pipe_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall & ~flush),
            .bubble    (1'b0),
            .reset_pc  (RESET_PC),
            .bubble_pc (in_pc),
            .d         (slot_q[k-1]),
            .q         (slot_q[k])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (flush || (!stall && !in_valid))
            bubble_cnt <= CW'(sat_inc(32'(bubble_cnt), 32'(CNT_MAX)));
         if (stall && !flush)
            stall_cnt <= CW'(sat_inc(32'(stall_cnt), 32'(CNT_MAX)));
      end
   end

   assign out_valid     = slot_q[DEPTH-1].valid;
   assign out_a3        = slot_q[DEPTH-1].a3;
   assign out_pc        = slot_q[DEPTH-1].pc;
   assign out_data      = slot_q[DEPTH-1].data[DW-1:0];
   assign out_reg_write = slot_q[DEPTH-1].reg_write;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3 with CW 2) share
// stimulus and are compared each cycle against an array-based reference model.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid, in_reg_write;
   logic [4:0]  in_a3;
   logic [31:0] in_pc, in_data;

   logic        o1_valid, o2_valid, o3_valid;
   logic [4:0]  o1_a3, o2_a3, o3_a3;
   logic [31:0] o1_pc, o2_pc, o3_pc;
   logic [31:0] o1_data, o2_data, o3_data;
   logic        o1_rw, o2_rw, o3_rw;
   logic [15:0] o1_bc, o1_sc, o2_bc, o2_sc;
   logic [1:0]  o3_bc, o3_sc;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DW(32), .DEPTH(1), .RESET_PC(32'h0000_3000), .CW(16)) u_d1 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_a3(in_a3), .in_pc(in_pc), .in_data(in_data), .in_reg_write(in_reg_write),
      .out_valid(o1_valid), .out_a3(o1_a3), .out_pc(o1_pc), .out_data(o1_data),
      .out_reg_write(o1_rw), .bubble_cnt(o1_bc), .stall_cnt(o1_sc));

   pipe_stage_reg #(.DW(32), .DEPTH(2), .RESET_PC(32'h0000_3000), .CW(16)) u_d2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_a3(in_a3), .in_pc(in_pc), .in_data(in_data), .in_reg_write(in_reg_write),
      .out_valid(o2_valid), .out_a3(o2_a3), .out_pc(o2_pc), .out_data(o2_data),
      .out_reg_write(o2_rw), .bubble_cnt(o2_bc), .stall_cnt(o2_sc));

   pipe_stage_reg #(.DW(32), .DEPTH(3), .RESET_PC(32'h0000_3000), .CW(2)) u_d3 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_a3(in_a3), .in_pc(in_pc), .in_data(in_data), .in_reg_write(in_reg_write),
      .out_valid(o3_valid), .out_a3(o3_a3), .out_pc(o3_pc), .out_data(o3_data),
      .out_reg_write(o3_rw), .bubble_cnt(o3_bc), .stall_cnt(o3_sc));

   typedef struct {
      bit        valid;
      bit [4:0]  a3;
      bit [31:0] pc;
      bit [31:0] data;
      bit        reg_write;
   } ent_t;

   ent_t mdl [3][4];
   int   dep  [3] = '{1, 2, 3};
   int   cmax [3] = '{65535, 65535, 3};
   int   bcnt [3];
   int   scnt [3];
   int   checks = 0;
   int   errors = 0;
   bit   check_en = 1'b0;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic check_dut(input int i, input logic v, input logic [4:0] a3, input logic [31:0] pc,
                            input logic [31:0] data, input logic rw, input logic [15:0] bc, input logic [15:0] sc);
      ent_t e;
      e = mdl[i][dep[i]-1];
      check_output($sformatf("d%0d_valid", dep[i]), 64'(v), 64'(e.valid));
      check_output($sformatf("d%0d_a3", dep[i]), 64'(a3), 64'(e.a3));
      check_output($sformatf("d%0d_pc", dep[i]), 64'(pc), 64'(e.pc));
      check_output($sformatf("d%0d_data", dep[i]), 64'(data), 64'(e.data));
      check_output($sformatf("d%0d_reg_write", dep[i]), 64'(rw), 64'(e.reg_write));
      check_output($sformatf("d%0d_bubble_cnt", dep[i]), 64'(bc), 64'(bcnt[i]));
      check_output($sformatf("d%0d_stall_cnt", dep[i]), 64'(sc), 64'(scnt[i]));
   endtask

   // Reference behaviour: slot 0 receives the new entry and older entries
   // move one place toward the output, unless held or reset.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            for (int k = 0; k < 4; k++) mdl[i][k] = '{1'b0, 5'd0, 32'h0000_3000, 32'd0, 1'b0};
            bcnt[i] = 0;
            scnt[i] = 0;
         end else if (flush) begin
            for (int k = dep[i] - 1; k > 0; k--) mdl[i][k] = mdl[i][k-1];
            mdl[i][0] = '{1'b0, 5'd0, in_pc, 32'd0, 1'b0};
            if (bcnt[i] < cmax[i]) bcnt[i]++;
         end else if (stall) begin
            if (scnt[i] < cmax[i]) scnt[i]++;
         end else begin
            for (int k = dep[i] - 1; k > 0; k--) mdl[i][k] = mdl[i][k-1];
            mdl[i][0] = '{in_valid, in_valid ? in_a3 : 5'd0, in_pc, in_data,
                          in_valid && (in_a3 != 5'd0) && in_reg_write};
            if (!in_valid && bcnt[i] < cmax[i]) bcnt[i]++;
         end
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic s, input logic f, input logic v,
                                 input logic [4:0] a3, input logic [31:0] pc, input logic [31:0] data,
                                 input logic rw);
      reset        = r;
      stall        = s;
      flush        = f;
      in_valid     = v;
      in_a3        = a3;
      in_pc        = pc;
      in_data      = data;
      in_reg_write = rw;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check_dut(0, o1_valid, o1_a3, o1_pc, o1_data, o1_rw, o1_bc, o1_sc);
         check_dut(1, o2_valid, o2_a3, o2_pc, o2_data, o2_rw, o2_bc, o2_sc);
         check_dut(2, o3_valid, o3_a3, o3_pc, o3_data, o3_rw, {14'd0, o3_bc}, {14'd0, o3_sc});
      end
   end

   initial begin
      check_en = 1'b1;

      // Reset values
      apply_stimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      apply_stimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      check_output("rst_pc", 64'(o1_pc), 64'h3000);
      check_output("rst_valid", 64'(o1_valid), 64'd0);
      check_output("rst_a3", 64'(o1_a3), 64'd0);
      check_output("rst_data", 64'(o1_data), 64'd0);
      check_output("rst_reg_write", 64'(o1_rw), 64'd0);
      check_output("rst_bubble_cnt", 64'(o1_bc), 64'd0);
      check_output("rst_stall_cnt", 64'(o1_sc), 64'd0);

      // Latency of a single entry through three slots
      apply_stimulus(0, 0, 0, 1, 5, 32'h3004, 32'hDEAD_BEEF, 1);
      apply_stimulus(0, 0, 0, 0, 0, 32'h3008, 32'h0, 0);
      check_output("lat_early_valid", 64'(o3_valid), 64'd0);
      apply_stimulus(0, 0, 0, 0, 0, 32'h300C, 32'h0, 0);
      check_output("lat_valid", 64'(o3_valid), 64'd1);
      check_output("lat_a3", 64'(o3_a3), 64'd5);
      check_output("lat_pc", 64'(o3_pc), 64'h3004);
      check_output("lat_data", 64'(o3_data), 64'hDEAD_BEEF);
      check_output("lat_reg_write", 64'(o3_rw), 64'd1);
      check_output("pre_stall_bc", 64'(o2_bc), 64'd2);

      // Four stalled cycles freeze every slot
      for (int n = 0; n < 4; n++) apply_stimulus(0, 1, 0, 1, 9, $urandom, $urandom, 1);
      check_output("stall_d3_pc", 64'(o3_pc), 64'h3004);
      check_output("stall_d3_data", 64'(o3_data), 64'hDEAD_BEEF);
      check_output("stall_d2_pc", 64'(o2_pc), 64'h3008);
      check_output("stall_cnt4", 64'(o2_sc), 64'd4);
      check_output("stall_bc_hold", 64'(o2_bc), 64'd2);
      check_output("stall_cnt_sat", 64'(o3_sc), 64'd3);

      // Flush wins over stall
      apply_stimulus(0, 1, 1, 1, 9, 32'h3010, 32'h1234, 1);
      check_output("flush_valid", 64'(o1_valid), 64'd0);
      check_output("flush_pc", 64'(o1_pc), 64'h3010);
      check_output("flush_data", 64'(o1_data), 64'd0);
      check_output("flush_sc", 64'(o2_sc), 64'd4);
      check_output("flush_bc", 64'(o2_bc), 64'd3);

      // Sanitising of destination and write enable
      apply_stimulus(0, 0, 0, 1, 0, 32'h3014, 32'hAAAA, 1);
      check_output("san1_rw", 64'(o1_rw), 64'd0);
      check_output("san1_a3", 64'(o1_a3), 64'd0);
      apply_stimulus(0, 0, 0, 0, 7, 32'h3018, 32'hBBBB, 1);
      check_output("san2_rw", 64'(o1_rw), 64'd0);
      check_output("san2_a3", 64'(o1_a3), 64'd0);

      // Saturating bubble counter, then reset mid-stream
      for (int n = 0; n < 5; n++) apply_stimulus(0, 0, 1, 1, 3, 32'h3020 + 32'(n * 4), 32'h55, 1);
      check_output("bc_sat", 64'(o3_bc), 64'd3);
      check_output("bc_d2", 64'(o2_bc), 64'd9);
      apply_stimulus(1, 1, 1, 1, 3, 32'h3100, 32'hFFFF, 1);
      check_output("midrst_pc", 64'(o3_pc), 64'h3000);
      check_output("midrst_valid", 64'(o3_valid), 64'd0);
      check_output("midrst_bc", 64'(o3_bc), 64'd0);
      check_output("midrst_sc", 64'(o3_sc), 64'd0);
      apply_stimulus(0, 0, 0, 0, 0, 32'h3200, 32'h0, 0);
      check_output("midrst_slot1_pc", 64'(o3_pc), 64'h3000);
      apply_stimulus(0, 0, 0, 0, 0, 32'h3204, 32'h0, 0);
      check_output("midrst_slot0_pc", 64'(o3_pc), 64'h3000);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         apply_stimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                        ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                        $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
